// File: rtl/sipo_deser.sv
// sipo_deser: serial-in / parallel-out deserializer feeding the PIPO stage.
// Assembles WIDTH serial bits into a word, hands it over through a one-word
// output slot with valid/ready, and backpressures the serial source while a
// finished word waits for the slot.
// Build option: define SIPO_PARITY_EN to append one even-parity bit per word
// and report mismatches on parity_err (tied 0 when undefined).
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          sin,
    input  logic                          sin_valid,
    output logic                          sin_ready,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          parity_err,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt
);

    localparam int CW = $clog2(WIDTH+2);

    typedef enum logic [1:0] {
        ST_SHIFT = 2'd0,
`ifdef SIPO_PARITY_EN
        ST_PAR   = 2'd1,
`endif
        ST_HOLD  = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   sr_q;
    logic [WIDTH-1:0]   sr_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   dout_q;
    logic               dout_valid_q;
    logic               accept;
    logic               last_data;
`ifdef SIPO_PARITY_EN
    logic               par_q;
    logic               perr_q;
`endif

    // Ready depends only on state and reset, never on sin_valid.
    assign sin_ready  = rst & (state_q != ST_HOLD);
    assign accept     = sin_valid & sin_ready & ~clr;
    assign last_data  = (cnt_q == CW'(WIDTH-1));

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_cnt    = cnt_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // Next shift-register value for an accepted bit, in the configured order.
    always_comb begin
        sr_d = sr_q;
        if (MSB_FIRST != 0) begin
            sr_d = {sr_q[WIDTH-2:0], sin};
        end else begin
            sr_d = {sin, sr_q[WIDTH-1:1]};
        end
    end

    // Collection FSM plus the registered output slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_SHIFT;
            sr_q         <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
`endif
        end else begin
            // A consumer handshake frees the slot; a HOLD reload below wins.
            if (dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            if (clr) begin
                // Flush the partial/held word; the output slot is untouched.
                state_q <= ST_SHIFT;
                sr_q    <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        if (accept) begin
                            sr_q  <= sr_d;
                            cnt_q <= cnt_q + CW'(1);
                            if (last_data) begin
`ifdef SIPO_PARITY_EN
                                state_q <= ST_PAR;
`else
                                state_q <= ST_HOLD;
`endif
                            end
                        end
                    end
`ifdef SIPO_PARITY_EN
                    ST_PAR: begin
                        if (accept) begin
                            par_q   <= sin;
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= ST_HOLD;
                        end
                    end
`endif
                    ST_HOLD: begin
                        // Load when the slot is empty or being drained this edge.
                        if (!dout_valid_q || dout_ready) begin
                            dout_q       <= sr_q;
                            dout_valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
                            perr_q       <= (^sr_q) ^ par_q;
`endif
                            cnt_q        <= '0;
                            state_q      <= ST_SHIFT;
                        end
                    end
                    default: begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SIPO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    // Counter never runs past the word length.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
        cnt_q <= CW'(NBITS));

    // Source is never told ready while held in reset.
    a_rdy_rst: assert property (@(posedge clk) !rst |-> !sin_ready);

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed vector table plus randomized run against a
// queue-based reference model. Two DUTs (MSB-first and LSB-first) share
// all inputs so both bit orders are checked on every cycle.
module tb_sipo_deser;

    localparam int W  = 4;
    localparam int CW = $clog2(W+2);
`ifdef SIPO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic          clk;
    logic          rst;
    logic          clr;
    logic          sin;
    logic          sin_valid;
    logic          dout_ready;
    logic          rdy_m, rdy_l;
    logic [W-1:0]  dout_m, dout_l;
    logic          dv_m, dv_l;
    logic          pe_m, pe_l;
    logic [CW-1:0] cnt_m, cnt_l;

    int checks = 0;
    int errors = 0;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
        .sin_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m),
        .dout_ready(dout_ready), .parity_err(pe_m), .bit_cnt(cnt_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
        .sin_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l),
        .dout_ready(dout_ready), .parity_err(pe_l), .bit_cnt(cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit           q_bits[$];
    bit           m_pend;
    logic [W-1:0] m_pm, m_pl;
    bit           m_pp;
    bit           m_v;
    logic [W-1:0] m_dm, m_dl;
    bit           m_pe;

    function automatic void model_reset();
        q_bits.delete();
        m_pend = 0; m_pm = '0; m_pl = '0; m_pp = 0;
        m_v = 0; m_dm = '0; m_dl = '0; m_pe = 0;
    endfunction

    // Advance the model by one edge using the inputs currently driven.
    function automatic void model_step();
        bit old_v;
        int ones;
        if (!rst) begin
            model_reset();
        end else begin
            old_v = m_v;
            if (dout_ready) m_v = 0;
            if (clr) begin
                q_bits.delete();
                m_pend = 0;
            end else if (m_pend) begin
                if (!old_v || dout_ready) begin
                    m_v = 1; m_dm = m_pm; m_dl = m_pl; m_pe = m_pp; m_pend = 0;
                end
            end else if (sin_valid) begin
                q_bits.push_back(sin);
                if (q_bits.size() == NB) begin
                    m_pm = '0; m_pl = '0; ones = 0;
                    for (int i = 0; i < W; i++) begin
                        m_pm[W-1-i] = q_bits[i];
                        m_pl[i]     = q_bits[i];
                        ones += int'(q_bits[i]);
                    end
`ifdef SIPO_PARITY_EN
                    ones += int'(q_bits[W]);
                    m_pp = (ones % 2) != 0;
`else
                    m_pp = 0;
`endif
                    m_pend = 1;
                    q_bits.delete();
                end
            end
        end
    endfunction

    task automatic model_check(input string tag);
        int ecnt;
        ecnt = m_pend ? NB : q_bits.size();
        check({tag, " dout_msb"}, 32'(dout_m), 32'(m_dm));
        check({tag, " dout_lsb"}, 32'(dout_l), 32'(m_dl));
        check({tag, " valid"},    32'({dv_m, dv_l}), 32'({m_v, m_v}));
        check({tag, " ready"},    32'({rdy_m, rdy_l}), 32'({2{rst & ~m_pend}}));
        check({tag, " bit_cnt"},  32'({cnt_m, cnt_l}), 32'({CW'(ecnt), CW'(ecnt)}));
        check({tag, " perr"},     32'({pe_m, pe_l}), 32'({m_pe, m_pe}));
    endtask

    // Drive one cycle of inputs, clock it, and keep the model in step.
    task automatic cyc(input logic r, input logic c, input logic sv, input logic s, input logic dr);
        rst = r; clr = c; sin_valid = sv; sin = s; dout_ready = dr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         r, c, sv, s, dr;
        logic         ev;
        logic [W-1:0] em, el;
        logic         erdy;
        int           ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic c, input logic sv, input logic s,
                                input logic dr, input logic ev, input logic [W-1:0] em,
                                input logic [W-1:0] el, input logic erdy, input int ecnt);
        vec_t v;
        v.r = r; v.c = c; v.sv = sv; v.s = s; v.dr = dr;
        v.ev = ev; v.em = em; v.el = el; v.erdy = erdy; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b0; clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; dout_ready = 1'b0;
        model_reset();

`ifndef SIPO_PARITY_EN
        //  rst clr sv sin dr | v  msb    lsb   rdy cnt
        add(0, 0, 0, 0, 0,  0, 4'h0, 4'h0, 0, 0);   // reset
        add(1, 0, 1, 1, 1,  0, 4'h0, 4'h0, 1, 1);   // basic 1011
        add(1, 0, 1, 0, 1,  0, 4'h0, 4'h0, 1, 2);
        add(1, 0, 1, 1, 1,  0, 4'h0, 4'h0, 1, 3);
        add(1, 0, 1, 1, 1,  0, 4'h0, 4'h0, 0, 4);
        add(1, 0, 0, 0, 1,  1, 4'hb, 4'hd, 1, 0);   // word visible
        add(1, 0, 0, 0, 1,  0, 4'hb, 4'hd, 1, 0);   // consumed
        add(1, 0, 1, 1, 0,  0, 4'hb, 4'hd, 1, 1);   // backpressure 1011
        add(1, 0, 1, 0, 0,  0, 4'hb, 4'hd, 1, 2);
        add(1, 0, 1, 1, 0,  0, 4'hb, 4'hd, 1, 3);
        add(1, 0, 1, 1, 0,  0, 4'hb, 4'hd, 0, 4);
        add(1, 0, 1, 0, 0,  1, 4'hb, 4'hd, 1, 0);   // bit not taken in HOLD
        add(1, 0, 1, 0, 0,  1, 4'hb, 4'hd, 1, 1);   // 0110
        add(1, 0, 1, 1, 0,  1, 4'hb, 4'hd, 1, 2);
        add(1, 0, 1, 1, 0,  1, 4'hb, 4'hd, 1, 3);
        add(1, 0, 1, 0, 0,  1, 4'hb, 4'hd, 0, 4);
        add(1, 0, 0, 0, 0,  1, 4'hb, 4'hd, 0, 4);   // stuck in HOLD
        add(1, 0, 0, 0, 1,  1, 4'h6, 4'h6, 1, 0);   // no-bubble reload
        add(1, 0, 0, 0, 1,  0, 4'h6, 4'h6, 1, 0);
        add(1, 0, 1, 1, 1,  0, 4'h6, 4'h6, 1, 1);   // flush mid-word
        add(1, 0, 1, 0, 1,  0, 4'h6, 4'h6, 1, 2);
        add(1, 1, 1, 1, 1,  0, 4'h6, 4'h6, 1, 0);
        add(1, 0, 1, 0, 1,  0, 4'h6, 4'h6, 1, 1);   // 0011
        add(1, 0, 1, 0, 1,  0, 4'h6, 4'h6, 1, 2);
        add(1, 0, 1, 1, 1,  0, 4'h6, 4'h6, 1, 3);
        add(1, 0, 1, 1, 1,  0, 4'h6, 4'h6, 0, 4);
        add(1, 0, 0, 0, 1,  1, 4'h3, 4'hc, 1, 0);
        add(1, 0, 1, 1, 0,  1, 4'h3, 4'hc, 1, 1);   // reset mid-word
        add(1, 0, 1, 0, 0,  1, 4'h3, 4'hc, 1, 2);
        add(1, 0, 1, 1, 0,  1, 4'h3, 4'hc, 1, 3);
        add(0, 0, 1, 1, 1,  0, 4'h0, 4'h0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 4'h0, 4'h0, 1, 1);   // fresh 0100
        add(1, 0, 1, 1, 1,  0, 4'h0, 4'h0, 1, 2);
        add(1, 0, 1, 0, 1,  0, 4'h0, 4'h0, 1, 3);
        add(1, 0, 1, 0, 1,  0, 4'h0, 4'h0, 0, 4);
        add(1, 0, 0, 0, 0,  1, 4'h4, 4'h2, 1, 0);
        add(1, 0, 1, 1, 0,  1, 4'h4, 4'h2, 1, 1);   // 1111 then flush in HOLD
        add(1, 0, 1, 1, 0,  1, 4'h4, 4'h2, 1, 2);
        add(1, 0, 1, 1, 0,  1, 4'h4, 4'h2, 1, 3);
        add(1, 0, 1, 1, 0,  1, 4'h4, 4'h2, 0, 4);
        add(1, 0, 0, 0, 0,  1, 4'h4, 4'h2, 0, 4);
        add(1, 1, 0, 0, 1,  0, 4'h4, 4'h2, 1, 0);   // held word dropped
        add(1, 0, 0, 0, 1,  0, 4'h4, 4'h2, 1, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].c, vecs[i].sv, vecs[i].s, vecs[i].dr);
            check($sformatf("vec%0d dout_msb", i), 32'(dout_m), 32'(vecs[i].em));
            check($sformatf("vec%0d dout_lsb", i), 32'(dout_l), 32'(vecs[i].el));
            check($sformatf("vec%0d valid", i), 32'({dv_m, dv_l}), 32'({2{vecs[i].ev}}));
            check($sformatf("vec%0d ready", i), 32'({rdy_m, rdy_l}), 32'({2{vecs[i].erdy}}));
            check($sformatf("vec%0d bit_cnt", i), 32'(cnt_m), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d perr", i), 32'({pe_m, pe_l}), 32'h0);
        end
`else
        // Parity sequences: 1011 + parity 1 is even, + parity 0 is a mismatch.
        cyc(0, 0, 0, 0, 0);
        model_check("par_rst");
        cyc(1, 0, 1, 1, 1); cyc(1, 0, 1, 0, 1); cyc(1, 0, 1, 1, 1); cyc(1, 0, 1, 1, 1);
        cyc(1, 0, 1, 1, 1);
        check("par_hold_cnt", 32'(cnt_m), 32'(W+1));
        check("par_hold_rdy", 32'(rdy_m), 32'h0);
        cyc(1, 0, 0, 0, 1);
        check("par_ok_valid", 32'(dv_m), 32'h1);
        check("par_ok_dout", 32'(dout_m), 32'hb);
        check("par_ok_perr", 32'({pe_m, pe_l}), 32'h0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 1, 1); cyc(1, 0, 1, 0, 1); cyc(1, 0, 1, 1, 1); cyc(1, 0, 1, 1, 1);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1);
        check("par_bad_dout", 32'(dout_m), 32'hb);
        check("par_bad_perr", 32'({pe_m, pe_l}), 32'h3);
        model_check("par_end");
`endif

        // ---------------- randomized run vs model ----------------
        cyc(0, 0, 0, 0, 0);
        model_check("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) >= 2),
                ($urandom_range(0, 99) < 4),
                ($urandom_range(0, 99) < 75),
                1'($urandom),
                ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 70 : 25)));
            model_check($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer that assembles a bit stream into WIDTH-bit words. It is the stage directly upstream of the 4-bit parallel register (PIPO) stage: each word it completes is presented on `dout` for the register to capture. A valid/ready handshake runs on both sides, with a one-word output buffer and backpressure to the serial source.

## Interface
- `WIDTH`, default 4: data bits per word (≥2).
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `dout[WIDTH-1]`; 0 means it lands in `dout[0]`.
- `clk`  in  1  single clock; all logic samples on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `clr`  in  1  synchronous flush of any partial or held word.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` carries a bit this cycle.
- `sin_ready`  out  1  deserializer accepts a bit this cycle.
- `dout`  out  WIDTH  assembled word, feeds the PIPO stage.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  downstream consumes `dout` this cycle.
- `parity_err`  out  1  parity mismatch for the current `dout`. Constant 0 when parity is compiled out.
- `bit_cnt`  out  $clog2(WIDTH+2)  bits accepted into the current word.

## Operation
- A bit is accepted on an edge where `rst`=1, `clr`=0, `sin_valid`=1 and `sin_ready`=1.
- Shift register update on accept:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
- States:
  - SHIFT: collecting data bits. `sin_ready`=1.
    - Accepting the bit that makes `bit_cnt` reach WIDTH moves to PAR if `SIPO_PARITY_EN` is defined, otherwise to HOLD.
  - PAR: collecting the parity bit. `sin_ready`=1.
    - On accept, the parity bit is latched and the state moves to HOLD. The shift register is unchanged.
  - HOLD: a word is complete. `sin_ready`=0.
    - If `dout_valid`=0 or `dout_ready`=1: dout <= sr, dout_valid <= 1, parity_err <= computed mismatch, `bit_cnt` <= 0, state moves to SHIFT.
    - Otherwise the state stays in HOLD.
- Output slot:
  - `dout_valid` clears on an edge with `dout_ready`=1 unless HOLD reloads the slot on the same edge.
  - `dout` and `parity_err` are stable while `dout_valid`=1 and `dout_ready`=0.
- `clr`=1 (with `rst`=1):
  - State moves to SHIFT and `bit_cnt` to 0; the shift register and any held word are discarded.
  - A bit presented on the same edge is dropped.
  - `dout`, `dout_valid` and `parity_err` are unaffected, except that a `dout_ready` handshake on the same edge still clears `dout_valid`.
- `bit_cnt` counts 0..WIDTH, or 0..WIDTH+1 with parity. It holds its final value in HOLD and never wraps past it.

## Timing
- `rst`=0 at an edge gives:
  - state SHIFT, sr = 0, `bit_cnt` = 0;
  - `dout` = 0, `dout_valid` = 0, `parity_err` = 0.
- While `rst`=0, all inputs are ignored and `sin_ready` is driven 0. Reset mid-word or while in HOLD loses that word.
- `sin_ready` is combinational from state and `rst` only, with no path from `sin_valid`.
- Latency: if the last bit (data or parity) is accepted at edge k and the slot is free, `dout_valid`=1 is visible after edge k+1.
- Peak throughput is one word per WIDTH+1 cycles, or WIDTH+2 with parity.
- In HOLD with the slot occupied and `dout_ready`=1 at edge m, the new word is loaded at edge m with no bubble.

## Configuration
- Macro: `SIPO_PARITY_EN`.
- Defined:
  - Each word carries one extra serial bit, for even parity: XOR of the WIDTH data bits and the parity bit equals 0.
  - `parity_err`=1 on mismatch. It is registered with `dout` and valid only while `dout_valid`=1.
  - The word is delivered regardless of the parity result.
- Undefined:
  - The PAR state does not exist.
  - `parity_err` is tied to 0.
  - Words are exactly WIDTH serial bits.

## Test plan
- Basic MSB-first word: WIDTH=4, MSB_FIRST=1, `dout_ready`=1, bits 1,0,1,1 on consecutive cycles -> `dout`=4'b1011, with `dout_valid` high one edge after the 4th accept.
- LSB-first word: MSB_FIRST=0, same bits 1,0,1,1 -> `dout`=4'b1101.
- Backpressure:
  - `dout_ready`=0; send 1011, then 0110.
  - Expect `dout` to stay 1011 and `sin_ready`=0 after the 8th bit (HOLD).
  - Pulse `dout_ready` for one cycle -> `dout`=0110 loaded on that edge, then `sin_ready`=1 on the next cycle.
- Flush mid-word: after 2 bits, assert `clr` together with `sin_valid`. Expect `bit_cnt`=0 and the bit dropped; the next 4 bits 0,0,1,1 give `dout`=4'b0011.
- Reset mid-word: after 3 bits, drive `rst`=0 for one edge. Expect all outputs 0 and `bit_cnt`=0; the next 4 bits form a fresh word.
- Parity (`SIPO_PARITY_EN` defined):
  - Data 1011 with parity 1 -> `parity_err`=0.
  - Data 1011 with parity 0 -> `parity_err`=1, `dout`=4'b1011.
